llc_recfifo: RTL and testbench
==============================

LLC_RECFIFO -- requirements
Module: llc_recfifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of stored frames; legal values are powers of two from 2 to 16.
REQ-002 SHALL have port clock  in  1  single system clock; all flops on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port activrreg  in  1  receive-register write enable from LLC FSM; level, may stay high several cycles.
REQ-005 SHALL have port initreqr  in  1  CPU init request; synchronous flush.
REQ-006 SHALL have port rec_id  in  29  received identifier; a standard ID occupies [28:18].
REQ-007 SHALL have port rec_ide  in  1  extended-frame flag.
REQ-008 SHALL have port rec_rtr  in  1  remote-frame flag.
REQ-009 SHALL have port rec_dlc  in  4  received DLC, raw.
REQ-010 SHALL have port rec_data  in  64  payload; byte 0 is bits [63:56].
REQ-011 SHALL have port rd_pop  in  1  CPU pop strobe, one pulse per frame.
REQ-012 SHALL have port ovfl_clr  in  1  clears the sticky overflow flag.
REQ-013 SHALL have ports rd_id/rd_ide/rd_rtr/rd_dlc/rd_data  out  29/1/1/4/64  head entry fields.
REQ-014 SHALL have port count  out  clog2(DEPTH)+1  number of stored frames.
REQ-015 SHALL have ports empty  out  1  and  full  out  1.
REQ-016 SHALL have port ovfl  out  1  sticky flag: a frame was lost.

Function
REQ-017 SHALL register activrreg into activrreg_d; push = activrreg AND NOT activrreg_d, so one push occurs per LLC write burst.
REQ-018 SHALL capture all rec_* fields on the clock edge where push is true.
REQ-019 SHALL compute len = 0 if rec_rtr=1, else min(rec_dlc,8); payload bytes k>=len SHALL be stored as 0x00; rec_dlc SHALL be stored unmodified.
REQ-020 SHALL, on a push with full=0, write the entry at the write pointer, advance the pointer modulo DEPTH and increment count.
REQ-021 SHALL, on rd_pop with empty=0, advance the read pointer modulo DEPTH and decrement count; rd_pop with empty=1 SHALL be ignored.
REQ-022 SHALL, on push and pop in the same cycle with full=1, perform both; count stays DEPTH and ovfl is unchanged.
REQ-023 SHALL, on push and pop in the same cycle with empty=1, store the push, ignore the pop, and set count to 1.
REQ-024 SHALL, on push with full=1 and no pop, discard the frame, leave the storage unchanged and set ovfl.
REQ-025 SHALL clear ovfl on ovfl_clr; a same-cycle overflow event SHALL win, leaving ovfl=1.
REQ-026 SHALL drive the rd_* outputs from the head entry; a pushed frame SHALL be visible one cycle after its push edge. rd_* SHALL read all-zero when empty=1.
REQ-027 SHALL derive empty=(count==0) and full=(count==DEPTH) from registered count, with no combinational path from any input.
REQ-028 SHALL, on initreqr=1, zero the pointers, count and ovfl on the next edge; initreqr SHALL take priority over push and pop in the same cycle. Stored data need not be cleared.
REQ-029 SHALL avoid a spurious push when activrreg is high across the end of reset or initreqr, because activrreg_d tracks activrreg at all times except during reset.

Reset
REQ-030 SHALL, while reset=1, asynchronously set the pointers=0, count=0, ovfl=0 and activrreg_d=0; empty=1, full=0 and rd_*=0.
REQ-031 SHALL NOT treat reset asserted mid-push as a push; after reset release, a new rising edge of activrreg is required.

Structure
REQ-032 SHALL place DEPTH default, ENTRY_W=99, field bit offsets (id, ide, rtr, dlc, data) and the len/zero-mask function in shared package llc_recfifo_pkg.
REQ-033 SHALL implement storage as one sub-module llc_recfifo_mem (DEPTH x ENTRY_W, 1 write port, 1 asynchronous read port, no reset on the array); pointer and count control SHALL stay in llc_recfifo.

Verification
REQ-034 SHALL verify: activrreg high for 3 cycles with id=0x1ABCDE01, dlc=8, data=0x0102030405060708 -> exactly one push, count=1, rd_* match next cycle.
REQ-035 SHALL verify: dlc=3, data=0xAABBCCDDEEFF1122 -> rd_data=0xAABBCC0000000000, rd_dlc=3; a second frame with rtr=1 -> rd_data=0.
REQ-036 SHALL verify: 5 pushes with DEPTH=4 and no pops -> count=4, full=1, ovfl=1, head still frame 1; 4 pops -> frames 1-4 in order, then empty=1.
REQ-037 SHALL verify: full FIFO with push and rd_pop in the same cycle -> count=4, ovfl=0, new frame at the tail; empty FIFO with push+pop -> count=1.
REQ-038 SHALL verify: initreqr during push with count=2 -> count=0, empty=1; reset pulse while activrreg=1, then release -> no push until activrreg falls and rises again.
REQ-039 SHALL verify: ovfl_clr in the same cycle as an overflow push -> ovfl=1; ovfl_clr alone -> ovfl=0 next cycle.

Source files
------------

// File: rtl/llc_recfifo_pkg.sv
// llc_recfifo_pkg
// Shared definitions for the LLC receive FIFO: default depth, the packed
// entry layout (identifier, flags, DLC, payload) and the payload masking
// helper that zeroes bytes beyond the frame's data length.
package llc_recfifo_pkg;

  localparam int DEPTH_DEF = 4;

  localparam int ID_W    = 29;
  localparam int DLC_W   = 4;
  localparam int DATA_W  = 64;
  localparam int ENTRY_W = 99;

  // Entry layout, LSB first: data | dlc | rtr | ide | id
  localparam int DATA_LSB = 0;
  localparam int DLC_LSB  = 64;
  localparam int RTR_BIT  = 68;
  localparam int IDE_BIT  = 69;
  localparam int ID_LSB   = 70;

  // Number of payload bytes that carry data: none for remote frames,
  // DLC values above 8 saturate at 8.
  function automatic logic [3:0] frame_len(input logic rtr, input logic [3:0] dlc);
    if (rtr) begin
      return 4'd0;
    end else if (dlc > 4'd8) begin
      return 4'd8;
    end else begin
      return dlc;
    end
  endfunction

  // Byte 0 sits in bits [63:56]; bytes at index >= len are forced to zero.
  function automatic logic [63:0] mask_payload(input logic [63:0] data,
                                               input logic rtr,
                                               input logic [3:0] dlc);
    logic [3:0]  len;
    logic [63:0] m;
    len = frame_len(rtr, dlc);
    m   = data;
    for (int k = 0; k < 8; k++) begin
      if (k >= int'(len)) begin
        m[63-8*k -: 8] = 8'h00;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/llc_recfifo_mem.sv
// llc_recfifo_mem
// Frame storage for the receive FIFO: DEPTH entries of ENTRY_W bits,
// one synchronous write port and one asynchronous read port. The array
// has no reset; validity is tracked by the pointer/count logic in the top.
// Ports:
//   clock_i  - system clock
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write data (packed entry)
//   raddr_i  - read address
//   rdata_o  - read data, combinational from raddr_i
module llc_recfifo_mem
  import llc_recfifo_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clock_i,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [ENTRY_W-1:0] wdata_i,
  input  logic [AW-1:0]      raddr_i,
  output logic [ENTRY_W-1:0] rdata_o
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clock_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/llc_recfifo.sv
// llc_recfifo
// Receive FIFO between the LLC state machine and the CPU. A frame is pushed
// once per rising edge of activrreg; the CPU reads the head entry from rd_*
// and pops it with rd_pop. A push into a full FIFO without a same-cycle pop
// is dropped and raises the sticky ovfl flag.
// Ports:
//   clock, reset         - clock, asynchronous active-high reset
//   activrreg            - LLC write enable (level; rising edge = push)
//   initreqr             - synchronous flush of pointers, count and ovfl
//   rec_id/ide/rtr/dlc/data - incoming frame fields
//   rd_pop               - pop the head frame
//   ovfl_clr             - clear ovfl (a same-cycle overflow wins)
//   rd_id/ide/rtr/dlc/data - head frame fields, zero when empty
//   count, empty, full   - occupancy, all from registered count
//   ovfl                 - sticky lost-frame flag
// Handshake: push and pop are single-cycle events with no backpressure;
// a push is accepted when not full or when a pop happens in the same cycle,
// a pop is accepted when not empty.
module llc_recfifo
  import llc_recfifo_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     activrreg,
  input  logic                     initreqr,
  input  logic [28:0]              rec_id,
  input  logic                     rec_ide,
  input  logic                     rec_rtr,
  input  logic [3:0]               rec_dlc,
  input  logic [63:0]              rec_data,
  input  logic                     rd_pop,
  input  logic                     ovfl_clr,
  output logic [28:0]              rd_id,
  output logic                     rd_ide,
  output logic                     rd_rtr,
  output logic [3:0]               rd_dlc,
  output logic [63:0]              rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     ovfl
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovfl_q, ovfl_d;
  // Delayed copy of activrreg used for edge detection.
  logic          act_dly_q;
  // Set once activrreg has been seen low after reset; a level that is
  // already high when reset releases must not count as a rising edge.
  logic          armed_q;

  logic               empty_w, full_w;
  logic               push, pop_ok, wr_en, lost;
  logic [ENTRY_W-1:0] wdata, head;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == CW'(DEPTH));

  assign push   = activrreg & ~act_dly_q & armed_q;
  assign pop_ok = rd_pop & ~empty_w;
  // When full, a same-cycle pop frees the slot the push needs.
  assign wr_en  = ~initreqr & push & (~full_w | pop_ok);
  assign lost   = ~initreqr & push & full_w & ~pop_ok;

  assign wdata = {rec_id, rec_ide, rec_rtr, rec_dlc,
                  mask_payload(rec_data, rec_rtr, rec_dlc)};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovfl_d   = ovfl_q;
    if (initreqr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovfl_d   = 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(wr_en) - CW'(pop_ok);
      if (lost) begin
        ovfl_d = 1'b1;
      end else if (ovfl_clr) begin
        ovfl_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovfl_q    <= 1'b0;
      act_dly_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovfl_q    <= ovfl_d;
      act_dly_q <= activrreg;
      if (!activrreg) begin
        armed_q <= 1'b1;
      end
    end
  end

  llc_recfifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clock_i (clock),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  assign rd_id   = empty_w ? '0 : head[ID_LSB +: ID_W];
  assign rd_ide  = empty_w ? 1'b0 : head[IDE_BIT];
  assign rd_rtr  = empty_w ? 1'b0 : head[RTR_BIT];
  assign rd_dlc  = empty_w ? '0 : head[DLC_LSB +: DLC_W];
  assign rd_data = empty_w ? '0 : head[DATA_LSB +: DATA_W];

  assign count = count_q;
  assign empty = empty_w;
  assign full  = full_w;
  assign ovfl  = ovfl_q;

endmodule

// File: tb/tb_llc_recfifo.sv
module tb_llc_recfifo;

  localparam int DEPTH = 4;

  logic        clock, reset, activrreg, initreqr;
  logic [28:0] rec_id;
  logic        rec_ide, rec_rtr;
  logic [3:0]  rec_dlc;
  logic [63:0] rec_data;
  logic        rd_pop, ovfl_clr;
  logic [28:0] rd_id;
  logic        rd_ide, rd_rtr;
  logic [3:0]  rd_dlc;
  logic [63:0] rd_data;
  logic [2:0]  count;
  logic        empty, full, ovfl;

  logic [98:0] head_w;
  assign head_w = {rd_id, rd_ide, rd_rtr, rd_dlc, rd_data};

  logic [98:0] exp_q[$];
  logic        model_ovfl;
  int          total;
  int          bad;

  llc_recfifo #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .activrreg(activrreg), .initreqr(initreqr),
    .rec_id(rec_id), .rec_ide(rec_ide), .rec_rtr(rec_rtr), .rec_dlc(rec_dlc),
    .rec_data(rec_data), .rd_pop(rd_pop), .ovfl_clr(ovfl_clr),
    .rd_id(rd_id), .rd_ide(rd_ide), .rd_rtr(rd_rtr), .rd_dlc(rd_dlc),
    .rd_data(rd_data), .count(count), .empty(empty), .full(full), .ovfl(ovfl)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // expected stored entry: payload bytes past the data length read as zero
  function automatic logic [98:0] mk(input logic [28:0] id, input logic ide,
                                     input logic rtr, input logic [3:0] dlc,
                                     input logic [63:0] data);
    int n;
    logic [63:0] d;
    d = data;
    if (rtr) n = 0;
    else if (dlc > 4'd8) n = 8;
    else n = int'(dlc);
    for (int b = n; b < 8; b++) d[63-8*b -: 8] = 8'h00;
    return {id, ide, rtr, dlc, d};
  endfunction

  function automatic logic [98:0] sb_head();
    if (exp_q.size() == 0) return '0;
    return exp_q[0];
  endfunction

  // driver tasks
  task automatic set_frame(input logic [28:0] id, input logic ide, input logic rtr,
                           input logic [3:0] dlc, input logic [63:0] data);
    rec_id = id; rec_ide = ide; rec_rtr = rtr; rec_dlc = dlc; rec_data = data;
  endtask

  task automatic push_frame(input logic [28:0] id, input logic ide, input logic rtr,
                            input logic [3:0] dlc, input logic [63:0] data,
                            input logic clr);
    set_frame(id, ide, rtr, dlc, data);
    activrreg = 1'b1;
    ovfl_clr  = clr;
    @(posedge clock); #1;
    activrreg = 1'b0;
    ovfl_clr  = 1'b0;
    if (exp_q.size() < DEPTH) exp_q.push_back(mk(id, ide, rtr, dlc, data));
    else model_ovfl = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic push_rand(input logic clr);
    push_frame(29'($urandom), 1'($urandom), 1'b0, 4'($urandom_range(0, 15)),
               {$urandom, $urandom}, clr);
  endtask

  task automatic do_pop();
    rd_pop = 1'b1;
    @(posedge clock); #1;
    rd_pop = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic do_init();
    initreqr = 1'b1;
    @(posedge clock); #1;
    initreqr = 1'b0;
    exp_q.delete();
    model_ovfl = 1'b0;
  endtask

  // tests
  task automatic test_reset();
    reset = 1'b1; activrreg = 1'b0; initreqr = 1'b0; rd_pop = 1'b0; ovfl_clr = 1'b0;
    set_frame('0, 1'b0, 1'b0, '0, '0);
    #2;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if ({empty, full, ovfl} !== 3'b100) begin bad++; $display("FAIL reset_flags got=%b exp=100", {empty, full, ovfl}); end
    total++; if (head_w !== '0) begin bad++; $display("FAIL reset_head got=%h exp=0", head_w); end
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_release_count got=%0d exp=0", count); end
  endtask

  task automatic test_single_push();
    set_frame(29'h1ABCDE01, 1'b1, 1'b0, 4'd8, 64'h0102030405060708);
    activrreg = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      if (i == 0) exp_q.push_back(mk(29'h1ABCDE01, 1'b1, 1'b0, 4'd8, 64'h0102030405060708));
      total++; if (count !== 3'(exp_q.size())) begin bad++; $display("FAIL single_count cyc=%0d got=%0d exp=%0d", i, count, exp_q.size()); end
      total++; if (head_w !== sb_head()) begin bad++; $display("FAIL single_head cyc=%0d got=%h exp=%h", i, head_w, sb_head()); end
    end
    activrreg = 1'b0;
    @(posedge clock); #1;
    total++; if (rd_data !== 64'h0102030405060708) begin bad++; $display("FAIL single_data got=%h exp=0102030405060708", rd_data); end
    do_pop();
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL single_empty got=%b exp=1", empty); end
  endtask

  task automatic test_mask();
    logic [63:0] d15;
    d15 = {$urandom, $urandom};
    push_frame(29'h0000_0123, 1'b0, 1'b0, 4'd3, 64'hAABBCCDDEEFF1122, 1'b0);
    push_frame(29'h0000_0456, 1'b0, 1'b1, 4'd8, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    push_frame(29'h1555_5555, 1'b1, 1'b0, 4'd15, d15, 1'b0);
    total++; if (rd_data !== 64'hAABBCC0000000000) begin bad++; $display("FAIL mask_dlc3_data got=%h exp=aabbcc0000000000", rd_data); end
    total++; if (rd_dlc !== 4'd3) begin bad++; $display("FAIL mask_dlc3_dlc got=%0d exp=3", rd_dlc); end
    do_pop();
    total++; if (rd_data !== 64'h0) begin bad++; $display("FAIL mask_rtr_data got=%h exp=0", rd_data); end
    total++; if ({rd_rtr, rd_dlc} !== 5'b1_1000) begin bad++; $display("FAIL mask_rtr_flags got=%b exp=11000", {rd_rtr, rd_dlc}); end
    do_pop();
    total++; if (rd_data !== d15 || rd_dlc !== 4'd15) begin bad++; $display("FAIL mask_dlc15 got=%h/%0d exp=%h/15", rd_data, rd_dlc, d15); end
    total++; if (head_w !== sb_head()) begin bad++; $display("FAIL mask_dlc15_head got=%h exp=%h", head_w, sb_head()); end
    do_pop();
    total++; if (count !== 3'd0) begin bad++; $display("FAIL mask_drain got=%0d exp=0", count); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) push_rand(1'b0);
    total++; if (count !== 3'd4) begin bad++; $display("FAIL ovf_count got=%0d exp=4", count); end
    total++; if ({full, ovfl} !== {1'b1, model_ovfl}) begin bad++; $display("FAIL ovf_flags got=%b exp=%b", {full, ovfl}, {1'b1, model_ovfl}); end
    for (int i = 0; i < 4; i++) begin
      total++; if (head_w !== sb_head()) begin bad++; $display("FAIL ovf_order idx=%0d got=%h exp=%h", i, head_w, sb_head()); end
      do_pop();
    end
    total++; if ({empty, count} !== 4'b1_000) begin bad++; $display("FAIL ovf_drain got=%b/%0d exp=1/0", empty, count); end
    total++; if (head_w !== '0) begin bad++; $display("FAIL ovf_empty_head got=%h exp=0", head_w); end
    do_pop();
    total++; if ({count, ovfl} !== {3'd0, model_ovfl}) begin bad++; $display("FAIL ovf_pop_empty got=%0d/%b exp=0/%b", count, ovfl, model_ovfl); end
  endtask

  task automatic test_ovfl_clr();
    for (int i = 0; i < 4; i++) push_rand(1'b0);
    push_rand(1'b1);
    total++; if (ovfl !== 1'b1) begin bad++; $display("FAIL clr_vs_ovf got=%b exp=1", ovfl); end
    ovfl_clr = 1'b1;
    @(posedge clock); #1;
    ovfl_clr = 1'b0;
    model_ovfl = 1'b0;
    total++; if (ovfl !== model_ovfl) begin bad++; $display("FAIL clr_alone got=%b exp=%b", ovfl, model_ovfl); end
    total++; if (head_w !== sb_head()) begin bad++; $display("FAIL clr_head got=%h exp=%h", head_w, sb_head()); end
    do_init();
  endtask

  task automatic test_back_to_back();
    logic [98:0] nf;
    for (int i = 0; i < 4; i++) push_rand(1'b0);
    total++; if (head_w !== sb_head()) begin bad++; $display("FAIL b2b_full_head got=%h exp=%h", head_w, sb_head()); end
    set_frame(29'h0ACE_0ACE, 1'b1, 1'b0, 4'd5, 64'h1122334455667788);
    nf = mk(29'h0ACE_0ACE, 1'b1, 1'b0, 4'd5, 64'h1122334455667788);
    activrreg = 1'b1; rd_pop = 1'b1;
    @(posedge clock); #1;
    activrreg = 1'b0; rd_pop = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(nf);
    total++; if ({count, ovfl} !== 4'b100_0) begin bad++; $display("FAIL b2b_full got=%0d/%b exp=4/0", count, ovfl); end
    @(posedge clock); #1;
    for (int i = 0; i < 4; i++) begin
      total++; if (head_w !== sb_head()) begin bad++; $display("FAIL b2b_order idx=%0d got=%h exp=%h", i, head_w, sb_head()); end
      do_pop();
    end
    set_frame(29'h0BEE_F00D, 1'b0, 1'b0, 4'd2, 64'hCAFEBABE00000000);
    nf = mk(29'h0BEE_F00D, 1'b0, 1'b0, 4'd2, 64'hCAFEBABE00000000);
    activrreg = 1'b1; rd_pop = 1'b1;
    @(posedge clock); #1;
    activrreg = 1'b0; rd_pop = 1'b0;
    exp_q.push_back(nf);
    total++; if (count !== 3'd1) begin bad++; $display("FAIL b2b_empty_count got=%0d exp=1", count); end
    total++; if (head_w !== sb_head()) begin bad++; $display("FAIL b2b_empty_head got=%h exp=%h", head_w, sb_head()); end
    @(posedge clock); #1;
    do_pop();
  endtask

  task automatic test_init_reset();
    push_rand(1'b0);
    push_rand(1'b0);
    total++; if (count !== 3'd2) begin bad++; $display("FAIL init_pre got=%0d exp=2", count); end
    set_frame(29'h0000_0777, 1'b0, 1'b0, 4'd1, 64'hFF00000000000000);
    activrreg = 1'b1; initreqr = 1'b1;
    @(posedge clock); #1;
    initreqr = 1'b0;
    exp_q.delete(); model_ovfl = 1'b0;
    total++; if ({empty, count} !== 4'b1_000) begin bad++; $display("FAIL init_flush got=%b/%0d exp=1/0", empty, count); end
    repeat (2) @(posedge clock);
    #1;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL init_no_spurious got=%0d exp=0", count); end
    activrreg = 1'b0;
    @(posedge clock); #1;
    // reset while activrreg is high
    activrreg = 1'b1; reset = 1'b1;
    #2;
    total++; if ({empty, full, count} !== 5'b10_000) begin bad++; $display("FAIL rst_mid got=%b exp=10000", {empty, full, count}); end
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      total++; if (count !== 3'd0) begin bad++; $display("FAIL rst_no_push cyc=%0d got=%0d exp=0", i, count); end
    end
    activrreg = 1'b0;
    @(posedge clock); #1;
    push_frame(29'h1234_5678, 1'b1, 1'b0, 4'd4, 64'h0A0B0C0D0E0F1011, 1'b0);
    total++; if (count !== 3'(exp_q.size())) begin bad++; $display("FAIL rst_new_edge got=%0d exp=%0d", count, exp_q.size()); end
    total++; if (head_w !== sb_head()) begin bad++; $display("FAIL rst_new_head got=%h exp=%h", head_w, sb_head()); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    model_ovfl = 1'b0;
    test_reset();
    test_single_push();
    test_mask();
    test_overflow();
    test_ovfl_clr();
    test_back_to_back();
    test_init_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
